// File: rtl/opl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : opl_pkg
// Purpose : Shared FSM encoding, default wait counts and timer width for the
//           OPL register-write arbiter.
// Revision: 1.0
// ============================================================================
package opl_pkg;

    localparam int C_ADDR_WAIT_DEF = 20;
    localparam int C_DATA_WAIT_DEF = 100;
    localparam int C_TMR_W         = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_AWAIT = 3'd2,
        ST_DATA  = 3'd3,
        ST_DWAIT = 3'd4
    } opl_state_e;

    // Returns the index of the requester to serve; contention goes to the
    // one that was not served last.
    function automatic logic opl_pick(input logic v0, input logic v1, input logic last);
        return (v0 && v1) ? ~last : v1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/opl_wait_timer.sv
`default_nettype none
// ============================================================================
// Module  : opl_wait_timer
// Purpose : cen-gated, loadable down-counter with a zero flag; never wraps.
// Revision: 1.0
// ============================================================================
module opl_wait_timer
    import opl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cen_i,
    input  logic               clr_i,
    input  logic               load_i,
    input  logic [C_TMR_W-1:0] load_val_i,
    input  logic               dec_i,
    output logic               zero_o
);

    localparam logic [C_TMR_W-1:0] C_ONE = C_TMR_W'(1);

    logic [C_TMR_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (cen_i) begin
            if (load_i) begin
                cnt_q <= load_val_i;
            end else if (dec_i && (cnt_q != '0)) begin
                cnt_q <= cnt_q - C_ONE;
            end
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/opl_write_arb.sv
`default_nettype none
// ============================================================================
// Module  : opl_write_arb
// Purpose : Arbitrates two register-write requesters onto the OPL write port,
//           sequencing the address and data strobes with cen-timed waits.
// Revision: 1.0
// ============================================================================
module opl_write_arb
    import opl_pkg::*;
#(
    parameter int ADDR_WAIT = C_ADDR_WAIT_DEF,
    parameter int DATA_WAIT = C_DATA_WAIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        enable,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic [15:0] req0_data,
    input  logic [15:0] req1_data,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic        opl_wr_n,
    output logic        opl_a0,
    output logic [7:0]  opl_din,
    output logic        busy,
    output logic        last_grant
);

    localparam logic [C_TMR_W-1:0] C_ADDR_LOAD = C_TMR_W'(ADDR_WAIT - 1);
    localparam logic [C_TMR_W-1:0] C_DATA_LOAD = C_TMR_W'(DATA_WAIT - 1);

    opl_state_e         state_q;
    logic               wr_n_q;
    logic               a0_q;
    logic [7:0]         din_q;
    logic [7:0]         value_q;
    logic               last_grant_q;

    logic               grant_open;
    logic               grant_sel;
    logic               xfer;
    logic [15:0]        sel_data;

    logic               tmr_clr;
    logic               tmr_load;
    logic               tmr_dec;
    logic               tmr_zero;
    logic [C_TMR_W-1:0] tmr_val;

    // Readies are combinational so a waiting requester is accepted on the
    // very first clk the FSM sits in IDLE.
    assign grant_open = ~rst & enable & (state_q == ST_IDLE);
    assign grant_sel  = opl_pick(req0_valid, req1_valid, last_grant_q);
    assign req0_ready = grant_open & req0_valid & ~grant_sel;
    assign req1_ready = grant_open & req1_valid &  grant_sel;
    assign xfer       = req0_ready | req1_ready;
    assign sel_data   = grant_sel ? req1_data : req0_data;

    always_comb begin
        tmr_clr  = ~enable;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_ADDR: begin
                tmr_load = 1'b1;
                tmr_val  = C_ADDR_LOAD;
            end
            ST_DATA: begin
                tmr_load = 1'b1;
                tmr_val  = C_DATA_LOAD;
            end
            ST_AWAIT, ST_DWAIT: begin
                tmr_dec = ~tmr_zero;
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
    end

    opl_wait_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .cen_i      (cen),
        .clr_i      (tmr_clr),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_n_q       <= 1'b1;
            a0_q         <= 1'b0;
            din_q        <= 8'h00;
            value_q      <= 8'h00;
            last_grant_q <= 1'b1;
        end else if (!enable) begin
            // Abort drops the write entirely; a0/din keep their last values.
            state_q <= ST_IDLE;
            wr_n_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        state_q      <= ST_ADDR;
                        wr_n_q       <= 1'b0;
                        a0_q         <= 1'b0;
                        din_q        <= sel_data[15:8];
                        value_q      <= sel_data[7:0];
                        last_grant_q <= grant_sel;
                    end
                end
                ST_ADDR: begin
                    if (cen) begin
                        wr_n_q  <= 1'b1;
                        state_q <= ST_AWAIT;
                    end
                end
                ST_AWAIT: begin
                    if (cen && tmr_zero) begin
                        state_q <= ST_DATA;
                        a0_q    <= 1'b1;
                        din_q   <= value_q;
                        wr_n_q  <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (cen) begin
                        wr_n_q  <= 1'b1;
                        state_q <= ST_DWAIT;
                    end
                end
                ST_DWAIT: begin
                    if (cen && tmr_zero) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    wr_n_q  <= 1'b1;
                end
            endcase
        end
    end

    assign opl_wr_n   = wr_n_q;
    assign opl_a0     = a0_q;
    assign opl_din    = din_q;
    assign busy       = (state_q != ST_IDLE);
    assign last_grant = last_grant_q;

endmodule
`default_nettype wire
